mem_bus_ctrl: RTL and testbench

//  CPU-side memory bus sequencer; consumes the 16-bit address the register file drives and

---
 rtl/mem_bus_if.sv | 27 ++
 rtl/mem_bus_ctrl.sv | 63 ++++++
 tb/tb_mem_bus_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: request/response and external memory signals of the CPU bus sequencer
interface mem_bus_if #(parameter int ADDR_W = 16, parameter int DATA_W = 8);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_fetch;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              m1t1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rd_n;
   logic              mem_wr_n;
   logic              mem_wait;
   modport master (
      output req_valid, req_write, req_fetch, req_addr, req_wdata, mem_rdata, mem_wait,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, m1t1, mem_addr, mem_wdata, mem_rd_n, mem_wr_n
   );
   modport slave (
      input  req_valid, req_write, req_fetch, req_addr, req_wdata, mem_rdata, mem_wait,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, m1t1, mem_addr, mem_wdata, mem_rd_n, mem_wr_n
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: runs one T1-T4 machine cycle per accepted request; define GB_BUS_WAIT_EN
// to let mem_wait stretch T3, aborting with rsp_err after MAX_WAIT held cycles.
module mem_bus_ctrl #(
   parameter int MAX_WAIT = 15
) (
   input logic     clk,
   input logic     rst,
   mem_bus_if.slave b
);
   localparam logic [2:0] IDLE = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4;
   logic [2:0] state;
   logic       wr_q, fe_q, accept, t3_done, capture;
   assign b.req_ready = state == IDLE || state == T4;
   assign accept      = b.req_valid && b.req_ready;
   assign b.rsp_valid = state == T4;
   assign b.m1t1      = state == T1 && fe_q && !wr_q;
   assign b.mem_rd_n  = !((state == T2 || state == T3) && !wr_q);
   assign b.mem_wr_n  = !((state == T2 || state == T3) && wr_q);
`ifdef GB_BUS_WAIT_EN
   logic [3:0] wait_cnt;
   logic       abort;
   assign abort   = b.mem_wait && wait_cnt == 4'(MAX_WAIT);
   assign t3_done = !b.mem_wait || abort;
   assign capture = !b.mem_wait;
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         b.rsp_err <= 1'b0;
      end else begin
         wait_cnt  <= (state == T3 && !t3_done) ? wait_cnt + 4'd1 : 4'd0;
         b.rsp_err <= state == T3 && abort;
      end
   end
`else
   logic unused_wait;
   assign unused_wait = &{1'b0, b.mem_wait, MAX_WAIT != 0};
   assign t3_done     = 1'b1;
   assign capture     = 1'b1;
   assign b.rsp_err   = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wr_q        <= 1'b0;
         fe_q        <= 1'b0;
         b.mem_addr  <= '0;
         b.mem_wdata <= '0;
         b.rsp_rdata <= '0;
      end else begin
         state <= b.req_ready ? (accept ? T1 : IDLE) :
                  state == T1 ? T2 :
                  state == T2 ? T3 :
                  state == T3 ? (t3_done ? T4 : T3) : IDLE;
         if (accept) begin
            wr_q       <= b.req_write;
            fe_q       <= b.req_fetch;
            b.mem_addr <= b.req_addr;
            if (b.req_write) b.mem_wdata <= b.req_wdata;
         end
         if (state == T3 && capture && !wr_q) b.rsp_rdata <= b.mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed and randomized checks of mem_bus_ctrl against a latency-based model
module tb_mem_bus_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0, errors = 0;
   mem_bus_if bus ();
   mem_bus_ctrl dut (.clk(clk), .rst(rst), .b(bus));
   always #5 clk = ~clk;

   // model: one transaction at a time, tracked by its accept cycle
   int         cyc = 0, st = 0, k;
   bit         busy = 0, t_wr = 0, t_fe = 0, en_cmp = 0;
   logic [7:0]  m_rdata = 0, m_wdata = 0;
   logic [15:0] m_addr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         busy    <= 0;
         m_rdata <= 0;
         m_addr  <= 0;
         m_wdata <= 0;
      end else begin
         if (busy && cyc == st + 3 && !t_wr) m_rdata <= bus.mem_rdata;
         if (bus.req_valid && (!busy || cyc == st + 4)) begin
            busy   <= 1;
            st     <= cyc;
            t_wr   <= bus.req_write;
            t_fe   <= bus.req_fetch;
            m_addr <= bus.req_addr;
            if (bus.req_write) m_wdata <= bus.req_wdata;
         end else if (busy && cyc == st + 4) busy <= 0;
      end
   end

   always @(negedge clk) begin
      if (en_cmp) begin
         k = cyc - st;
         chk("ready", bus.req_ready, !busy || k == 4);
         chk("rsp_valid", bus.rsp_valid, busy && k == 4);
         chk("m1t1", bus.m1t1, busy && k == 1 && t_fe && !t_wr);
         chk("rd_n", bus.mem_rd_n, !(busy && !t_wr && (k == 2 || k == 3)));
         chk("wr_n", bus.mem_wr_n, !(busy && t_wr && (k == 2 || k == 3)));
         chk("rsp_rdata", bus.rsp_rdata, m_rdata);
         chk("mem_addr", bus.mem_addr, m_addr);
         chk("mem_wdata", bus.mem_wdata, m_wdata);
         chk("rsp_err", bus.rsp_err, 0);
      end
   end

   initial begin
      rst = 1;
      bus.req_valid = 0; bus.req_write = 0; bus.req_fetch = 0;
      bus.req_addr = 0; bus.req_wdata = 0; bus.mem_rdata = 0; bus.mem_wait = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rst ready", bus.req_ready, 1);
      chk("rst rsp_valid", bus.rsp_valid, 0);
      chk("rst rdata", bus.rsp_rdata, 0);
      chk("rst err", bus.rsp_err, 0);
      chk("rst m1t1", bus.m1t1, 0);
      chk("rst addr", bus.mem_addr, 0);
      chk("rst wdata", bus.mem_wdata, 0);
      chk("rst rd_n", bus.mem_rd_n, 1);
      chk("rst wr_n", bus.mem_wr_n, 1);
      tick();
      rst = 0;
      en_cmp = 1;
      // opcode fetch
      bus.req_valid = 1; bus.req_write = 0; bus.req_fetch = 1;
      bus.req_addr = 16'h0100; bus.mem_rdata = 8'h3E;
      tick();
      bus.req_valid = 0;
      @(negedge clk);
      chk("f m1t1", bus.m1t1, 1);
      chk("f addr", bus.mem_addr, 16'h0100);
      chk("f rd_n T1", bus.mem_rd_n, 1);
      @(negedge clk);
      chk("f rd_n T2", bus.mem_rd_n, 0);
      chk("f m1t1 T2", bus.m1t1, 0);
      @(negedge clk);
      chk("f rd_n T3", bus.mem_rd_n, 0);
      @(negedge clk);
      chk("f valid", bus.rsp_valid, 1);
      chk("f rdata", bus.rsp_rdata, 8'h3E);
      chk("f rd_n T4", bus.mem_rd_n, 1);
      tick();
      // write then back-to-back read
      bus.req_valid = 1; bus.req_write = 1; bus.req_fetch = 0;
      bus.req_addr = 16'hC000; bus.req_wdata = 8'h5A; bus.mem_rdata = 8'h77;
      tick();
      bus.req_valid = 0;
      @(negedge clk);
      chk("w wr_n T1", bus.mem_wr_n, 1);
      chk("w m1t1", bus.m1t1, 0);
      @(negedge clk);
      chk("w wr_n T2", bus.mem_wr_n, 0);
      chk("w wdata", bus.mem_wdata, 8'h5A);
      chk("w rd_n T2", bus.mem_rd_n, 1);
      @(negedge clk);
      chk("w wr_n T3", bus.mem_wr_n, 0);
      @(negedge clk);
      chk("w valid", bus.rsp_valid, 1);
      chk("w rdata kept", bus.rsp_rdata, 8'h3E);
      chk("w ready T4", bus.req_ready, 1);
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 16'hC001;
      tick();
      bus.req_valid = 0;
      @(negedge clk);
      chk("b2b addr", bus.mem_addr, 16'hC001);
      chk("b2b valid T1", bus.rsp_valid, 0);
      chk("b2b ready T1", bus.req_ready, 0);
      repeat (3) @(negedge clk);
      chk("b2b valid", bus.rsp_valid, 1);
      chk("b2b rdata", bus.rsp_rdata, 8'h77);
      tick();
      // reset during T2 of a read
      bus.req_valid = 1; bus.req_addr = 16'h8000; bus.mem_rdata = 8'h99;
      tick();
      bus.req_valid = 0;
      tick();
      rst = 1;
      @(negedge clk);
      chk("r rd_n T2", bus.mem_rd_n, 0);
      tick();
      rst = 0;
      @(negedge clk);
      chk("r rd_n", bus.mem_rd_n, 1);
      chk("r valid", bus.rsp_valid, 0);
      chk("r ready", bus.req_ready, 1);
      tick();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_write = 1'($urandom_range(0, 1));
         bus.req_fetch = 1'($urandom_range(0, 1));
         bus.req_addr  = 16'($urandom);
         bus.req_wdata = 8'($urandom);
         bus.mem_rdata = 8'($urandom);
         rst = $urandom_range(0, 63) == 0;
`ifndef GB_BUS_WAIT_EN
         bus.mem_wait = 1'($urandom_range(0, 1));
`endif
         tick();
      end
      bus.req_valid = 0;
      rst = 0;
      bus.mem_wait = 0;
      tick();
      tick();
`ifdef GB_BUS_WAIT_EN
      en_cmp = 0;
      rst = 1;
      tick();
      rst = 0;
      bus.req_valid = 1; bus.req_write = 0; bus.req_fetch = 0;
      bus.req_addr = 16'hFF40; bus.mem_rdata = 8'hA5; bus.mem_wait = 1;
      tick();
      bus.req_valid = 0;
      for (int i = 1; i <= 7; i++) begin
         if (i == 6) bus.mem_wait = 0;
         @(negedge clk);
         chk("wait valid", bus.rsp_valid, i == 7);
         if (i == 7) begin
            chk("wait err", bus.rsp_err, 0);
            chk("wait rdata", bus.rsp_rdata, 8'hA5);
         end
         tick();
      end
      bus.req_valid = 1; bus.mem_rdata = 8'h11; bus.mem_wait = 1;
      tick();
      bus.req_valid = 0;
      for (int i = 1; i <= 19; i++) begin
         @(negedge clk);
         chk("to valid", bus.rsp_valid, i == 19);
         if (i == 19) begin
            chk("to err", bus.rsp_err, 1);
            chk("to rdata", bus.rsp_rdata, 8'hA5);
            chk("to rd_n", bus.mem_rd_n, 1);
         end
         tick();
      end
      bus.mem_wait = 0;
      @(negedge clk);
      chk("to err clr", bus.rsp_err, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
